// File: rtl/if_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours: opcode codes,
// instruction word field positions and the IF/ID register layout.
package if_fetch_pkg;

    localparam logic [2:0] OPNOP  = 3'b000;
    localparam logic [2:0] OPADD  = 3'b001;
    localparam logic [2:0] OPMUL  = 3'b010;
    localparam logic [2:0] OPADDI = 3'b011;

    localparam int OP_LSB   = 0;
    localparam int RD_LSB   = 3;
    localparam int RS1_LSB  = 8;
    localparam int RS2_LSB  = 13;
    localparam int IMM_LSB  = 18;
    localparam int RSVD_BIT = 30;
    localparam int HALT_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } ifid_t;

    localparam ifid_t IFID_NOP = '0;

endpackage

// File: rtl/if_fetch_stage_imem.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded program survives rst.
module if_imem #(
    parameter int DEPTH  = 32,
    parameter int IWIDTH = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [IWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [IWIDTH-1:0] rdata
);

    logic [IWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, run/halt control and the IF/ID register feeding idexwb_pipe.
// The memory write port is only honoured while fetch is not running.
module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int IWIDTH = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              stall,
    input  logic              imem_we,
    input  logic [AW-1:0]     imem_addr,
    input  logic [IWIDTH-1:0] imem_wdata,
    output logic [2:0]        opcode,
    output logic [4:0]        Rs1,
    output logic [4:0]        Rs2,
    output logic [4:0]        Rd,
    output logic [11:0]       imm,
    output logic              start,
    output logic              running,
    output logic              halted,
    output logic [AW-1:0]     pc
);

    fetch_state_e      state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic              start_q, start_d;
    logic [IWIDTH-1:0] fetch_word;
    ifid_t             fetched;
    logic              unused_rsvd;

    if_imem #(
        .DEPTH (DEPTH),
        .IWIDTH(IWIDTH),
        .AW    (AW)
    ) u_imem (
        .clk  (clk),
        .we   (imem_we && (state_q != ST_RUN)),
        .waddr(imem_addr),
        .wdata(imem_wdata),
        .raddr(pc_q),
        .rdata(fetch_word)
    );

    assign fetched.opcode = fetch_word[OP_LSB  +: 3];
    assign fetched.rd     = fetch_word[RD_LSB  +: 5];
    assign fetched.rs1    = fetch_word[RS1_LSB +: 5];
    assign fetched.rs2    = fetch_word[RS2_LSB +: 5];
    assign fetched.imm    = fetch_word[IMM_LSB +: 12];
    assign unused_rsvd    = fetch_word[RSVD_BIT];

    // go restarts from any state and beats stall; a HALT word is consumed
    // (pc advances past it) but never presented downstream.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        start_d = start_q;
        if (go) begin
            state_d = ST_RUN;
            pc_d    = '0;
            ifid_d  = IFID_NOP;
            start_d = 1'b0;
        end else if ((state_q == ST_RUN) && !stall) begin
            pc_d = pc_q + AW'(1);
            if (fetch_word[HALT_BIT]) begin
                state_d = ST_HALT;
                ifid_d  = IFID_NOP;
                start_d = 1'b0;
            end else begin
                ifid_d  = fetched;
                start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ifid_q  <= IFID_NOP;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            start_q <= start_d;
        end
    end

    assign opcode  = ifid_q.opcode;
    assign Rd      = ifid_q.rd;
    assign Rs1     = ifid_q.rs1;
    assign Rs2     = ifid_q.rs2;
    assign imm     = ifid_q.imm;
    assign start   = start_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);
    assign pc      = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, short programs, stall, dropped
// writes while running, PC wrap over the full memory and async reset mid-run.
module tb_if_fetch_stage;
    import if_fetch_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          stall = 1'b0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_addr = '0;
    logic [31:0]   imem_wdata = '0;
    logic [2:0]    opcode;
    logic [4:0]    Rs1, Rs2, Rd;
    logic [11:0]   imm;
    logic          start, running, halted;
    logic [AW-1:0] pc;

    int numAsserts = 0;
    int numFails   = 0;

    if_fetch_stage #(.DEPTH(DEPTH), .IWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .stall     (stall),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .opcode    (opcode),
        .Rs1       (Rs1),
        .Rs2       (Rs2),
        .Rd        (Rd),
        .imm       (imm),
        .start     (start),
        .running   (running),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later
    task automatic applyStimulus(input logic g, input logic s, input logic we,
                                 input logic [AW-1:0] a, input logic [31:0] d);
        go         = g;
        stall      = s;
        imem_we    = we;
        imem_addr  = a;
        imem_wdata = d;
        @(posedge clk);
        #1;
        go      = 1'b0;
        stall   = 1'b0;
        imem_we = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numAsserts++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] eOp, input logic [4:0] eRd,
                            input logic [4:0] eRs1, input logic [4:0] eRs2,
                            input logic [11:0] eImm, input logic eStart, input logic eRun,
                            input logic eHalt, input logic [AW-1:0] ePc);
        checkOutput({tag, ".opcode"},  32'(opcode),  32'(eOp));
        checkOutput({tag, ".Rd"},      32'(Rd),      32'(eRd));
        checkOutput({tag, ".Rs1"},     32'(Rs1),     32'(eRs1));
        checkOutput({tag, ".Rs2"},     32'(Rs2),     32'(eRs2));
        checkOutput({tag, ".imm"},     32'(imm),     32'(eImm));
        checkOutput({tag, ".start"},   32'(start),   32'(eStart));
        checkOutput({tag, ".running"}, 32'(running), 32'(eRun));
        checkOutput({tag, ".halted"},  32'(halted),  32'(eHalt));
        checkOutput({tag, ".pc"},      32'(pc),      32'(ePc));
    endtask

    // Stimulus runs as one linear sequence of directed steps
    initial begin
        logic [31:0] w;
        #2;
        checkAll("reset", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] three-word program ADDI, ADDI, HALT");
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0014_000B);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 32'h3FF4_0013);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 32'h8000_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("go", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p1c1", 3'b011, 5'd1, 5'd0, 5'd0, 12'h005, 1'b1, 1'b1, 1'b0, 5'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p1c2", 3'b011, 5'd2, 5'd0, 5'd0, 12'hFFD, 1'b1, 1'b1, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p1c3", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b1, 5'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkAll("haltStall", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b1, 5'd3);

        $display("[TB] rewrite after halt, stall, dropped write while running");
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_4119);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 32'h8000_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0022);
        checkAll("p2c1", 3'b011, 5'd1, 5'd0, 5'd0, 12'h005, 1'b1, 1'b1, 1'b0, 5'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p2c2", 3'b011, 5'd2, 5'd0, 5'd0, 12'hFFD, 1'b1, 1'b1, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkAll("stall1", 3'b011, 5'd2, 5'd0, 5'd0, 12'hFFD, 1'b1, 1'b1, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkAll("stall2", 3'b011, 5'd2, 5'd0, 5'd0, 12'hFFD, 1'b1, 1'b1, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p2c3", 3'b001, 5'd3, 5'd1, 5'd2, 12'h000, 1'b1, 1'b1, 1'b0, 5'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("p2c4", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b1, 5'd4);

        $display("[TB] full memory without HALT, pc wrap");
        for (int i = 0; i < DEPTH; i++) begin
            w = (32'(i * 3) << 18) | (32'(31 - i) << 13) | (32'(i) << 8) | (32'(i) << 3)
                | ((i == 5) ? 32'h7 : 32'(OPADD));
            applyStimulus(1'b0, 1'b0, 1'b1, AW'(i), w);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        checkAll("goStall", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            checkAll($sformatf("wrap%0d", i), (i == 5) ? 3'b111 : 3'b001, 5'(i), 5'(i),
                     5'(31 - i), 12'(i * 3), 1'b1, 1'b1, 1'b0, AW'(i + 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("reissue0", 3'b001, 5'd0, 5'd0, 5'd31, 12'h000, 1'b1, 1'b1, 1'b0, 5'd1);

        $display("[TB] asynchronous reset mid-run");
        rst = 1'b1;
        #1;
        checkAll("asyncRst", 3'b000, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkAll("memKept", 3'b001, 5'd1, 5'd1, 5'd30, 12'h003, 1'b1, 1'b1, 1'b0, 5'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
